// File: rtl/ram_bus_bridge_if.sv
// ram_bus_bridge_if: bundles the request/response bus and the RAM-side port
// of ram_bus_bridge.
//   req_*  : valid/ready request channel (byte address, write enable, byte
//            enables, write data)
//   rsp_*  : valid/ready response channel (read data, write echo, range error)
//   ram_*  : word address, write data, byte selects, write enable to the RAM,
//            and the RAM's registered read data coming back
// Modports: slave = bridge view, master = requester/RAM view.
interface ram_bus_bridge_if #(
  parameter int AW = 32,
  parameter int DW = 32,
  parameter int MW = 4
);
  logic          req_valid_i;
  logic          req_ready_o;
  logic [AW-1:0] req_addr_i;
  logic          req_we_i;
  logic [MW-1:0] req_be_i;
  logic [DW-1:0] req_wdata_i;

  logic          rsp_valid_o;
  logic          rsp_ready_i;
  logic [DW-1:0] rsp_rdata_o;
  logic          rsp_we_o;
  logic          rsp_err_o;

  logic [AW-1:0] ram_addr_o;
  logic [DW-1:0] ram_data_o;
  logic [MW-1:0] ram_sel_o;
  logic          ram_we_o;
  logic [DW-1:0] ram_data_i;

  modport slave (
    input  req_valid_i, req_addr_i, req_we_i, req_be_i, req_wdata_i,
    input  rsp_ready_i, ram_data_i,
    output req_ready_o, rsp_valid_o, rsp_rdata_o, rsp_we_o, rsp_err_o,
    output ram_addr_o, ram_data_o, ram_sel_o, ram_we_o
  );

  modport master (
    output req_valid_i, req_addr_i, req_we_i, req_be_i, req_wdata_i,
    output rsp_ready_i, ram_data_i,
    input  req_ready_o, rsp_valid_o, rsp_rdata_o, rsp_we_o, rsp_err_o,
    input  ram_addr_o, ram_data_o, ram_sel_o, ram_we_o
  );
endinterface

// File: rtl/ram_bus_bridge.sv
// ram_bus_bridge: adapts a valid/ready memory bus to a byte-enable data RAM
// with one-cycle read latency. One request in flight; the RAM's late read
// data is captured so a stalled response never depends on the RAM holding
// its read address.
// Ports:
//   clk  : clock, rising edge
//   rst  : synchronous active-high reset
//   bus  : ram_bus_bridge_if.slave (request, response and RAM signals)
//
// state      | meaning
// IDLE       | no response pending
// RESP_FIRST | response valid in the cycle after acceptance; read data
//            | passes straight through from the RAM
// RESP_HOLD  | response stalled; read data served from rdata_q
module ram_bus_bridge #(
  parameter int DP = 512,
  parameter int DW = 32,
  parameter int MW = 4,
  parameter int AW = 32
) (
  input logic           clk,
  input logic           rst,
  ram_bus_bridge_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    RESP_FIRST = 2'd1,
    RESP_HOLD  = 2'd2
  } state_t;

  localparam logic [AW-1:0] DP_W = AW'(DP);

  state_t        state_q, state_d;
  logic [AW-1:0] idx;
  logic [AW-1:0] addr_q;
  logic          in_range;
  logic          acc;
  logic          rsp_we_q, rsp_err_q, rsp_rd_q;
  logic [DW-1:0] rdata_q;
  logic [DW-1:0] rdata_d;
  logic          unused_addr_lsb;

  assign unused_addr_lsb = ^bus.req_addr_i[1:0];

  assign idx      = {2'b00, bus.req_addr_i[AW-1:2]};
  assign in_range = idx < DP_W;

  assign bus.req_ready_o = (state_q == IDLE) || bus.rsp_ready_i;
  // Gating with rst keeps a write presented during reset away from the RAM.
  assign acc = bus.req_valid_i && bus.req_ready_o && !rst;

  assign bus.ram_we_o   = acc && bus.req_we_i && in_range;
  assign bus.ram_sel_o  = bus.ram_we_o ? bus.req_be_i : '0;
  assign bus.ram_addr_o = acc ? idx : addr_q;
  assign bus.ram_data_o = bus.req_wdata_i;

  assign bus.rsp_valid_o = (state_q != IDLE);
  assign bus.rsp_rdata_o = rdata_d;
  assign bus.rsp_we_o    = rsp_we_q;
  assign bus.rsp_err_o   = rsp_err_q;

  always_comb begin
    state_d = state_q;
    rdata_d = '0;
    case (state_q)
      IDLE: begin
        if (acc) state_d = RESP_FIRST;
      end
      RESP_FIRST: begin
        rdata_d = rsp_rd_q ? bus.ram_data_i : '0;
        if (!bus.rsp_ready_i) state_d = RESP_HOLD;
        else if (acc)         state_d = RESP_FIRST;
        else                  state_d = IDLE;
      end
      RESP_HOLD: begin
        rdata_d = rdata_q;
        if (bus.rsp_ready_i) state_d = acc ? RESP_FIRST : IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      addr_q    <= '0;
      rdata_q   <= '0;
      rsp_we_q  <= 1'b0;
      rsp_err_q <= 1'b0;
      rsp_rd_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      if (acc) begin
        addr_q    <= idx;
        rsp_we_q  <= bus.req_we_i;
        rsp_err_q <= !in_range;
        rsp_rd_q  <= !bus.req_we_i && in_range;
      end
      // Capture only in the cycle the RAM output is still valid for us.
      if (state_q == RESP_FIRST && !bus.rsp_ready_i)
        rdata_q <= rdata_d;
    end
  end

endmodule

// File: tb/tb_ram_bus_bridge.sv
module tb_ram_bus_bridge;
  localparam int DP = 512;
  localparam int DW = 32;
  localparam int MW = 4;
  localparam int AW = 32;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  ram_bus_bridge_if #(.AW(AW), .DW(DW), .MW(MW)) bus_if ();

  ram_bus_bridge #(.DP(DP), .DW(DW), .MW(MW), .AW(AW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus_if)
  );

  // Stand-in for gen_ram: byte-select writes, registered read address.
  logic [DW-1:0] mem [0:DP-1];
  logic [8:0]    raddr_q;
  logic          clr, poke_en;
  logic [8:0]    poke_idx;
  logic [DW-1:0] poke_val;

  always @(posedge clk) begin
    if (clr) begin
      for (int i = 0; i < DP; i++) mem[i] <= '0;
      raddr_q <= '0;
    end else if (poke_en) begin
      mem[poke_idx] <= poke_val;
    end else if (bus_if.ram_we_o) begin
      for (int b = 0; b < MW; b++)
        if (bus_if.ram_sel_o[b])
          mem[bus_if.ram_addr_o[8:0]][8*b +: 8] <= bus_if.ram_data_o[8*b +: 8];
    end else begin
      raddr_q <= bus_if.ram_addr_o[8:0];
    end
  end
  assign bus_if.ram_data_i = mem[raddr_q];

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  // Drives one cycle of inputs just after the edge, returns at the falling edge.
  task automatic drive(input logic v, input logic [31:0] a, input logic we,
                       input logic [3:0] be, input logic [31:0] wd, input logic rr);
    @(posedge clk); #1;
    bus_if.req_valid_i = v;
    bus_if.req_addr_i  = a;
    bus_if.req_we_i    = we;
    bus_if.req_be_i    = be;
    bus_if.req_wdata_i = wd;
    bus_if.rsp_ready_i = rr;
    @(negedge clk);
  endtask

  typedef struct {
    logic v; logic [31:0] a; logic we; logic [3:0] be; logic [31:0] wd; logic rr;
    logic e_rdy; logic e_rv; logic [31:0] e_rd; logic e_rwe; logic e_err;
    logic e_mwe; logic [3:0] e_sel; logic [31:0] e_addr;
  } vec_t;

  function automatic vec_t mk(logic v, logic [31:0] a, logic we, logic [3:0] be,
                              logic [31:0] wd, logic rr, logic e_rdy, logic e_rv,
                              logic [31:0] e_rd, logic e_rwe, logic e_err,
                              logic e_mwe, logic [3:0] e_sel, logic [31:0] e_addr);
    vec_t r;
    r.v = v; r.a = a; r.we = we; r.be = be; r.wd = wd; r.rr = rr;
    r.e_rdy = e_rdy; r.e_rv = e_rv; r.e_rd = e_rd; r.e_rwe = e_rwe; r.e_err = e_err;
    r.e_mwe = e_mwe; r.e_sel = e_sel; r.e_addr = e_addr;
    return r;
  endfunction

  localparam int NV = 15;
  vec_t vt [NV];

  typedef struct { logic [31:0] rd; logic we; logic err; } exp_t;
  exp_t          q [$];
  logic [31:0]   ref_mem [0:15];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    //          v  addr     we be   wdata        rr  rdy rv rdata         rwe err mwe sel  ram_addr
    vt[0]  = mk(0, 'h000,   0, 'h0, 'h0,         1,  1,  0, 'h0,          0,  0,  0,  'h0, 'h000);
    vt[1]  = mk(1, 'h010,   1, 'hF, 'hDEADBEEF,  1,  1,  0, 'h0,          0,  0,  1,  'hF, 'h004);
    vt[2]  = mk(1, 'h010,   0, 'h0, 'h0,         1,  1,  1, 'h0,          1,  0,  0,  'h0, 'h004);
    vt[3]  = mk(1, 'h014,   1, 'hF, 'h11223344,  1,  1,  1, 'hDEADBEEF,   0,  0,  1,  'hF, 'h005);
    vt[4]  = mk(1, 'h014,   1, 'h2, 'h0000AB00,  1,  1,  1, 'h0,          1,  0,  1,  'h2, 'h005);
    vt[5]  = mk(1, 'h017,   0, 'h0, 'h0,         1,  1,  1, 'h0,          1,  0,  0,  'h0, 'h005);
    vt[6]  = mk(1, 'h018,   1, 'h0, 'hFFFFFFFF,  1,  1,  1, 'h1122AB44,   0,  0,  1,  'h0, 'h006);
    vt[7]  = mk(1, 'h018,   0, 'h0, 'h0,         1,  1,  1, 'h0,          1,  0,  0,  'h0, 'h006);
    vt[8]  = mk(1, 'h800,   1, 'hF, 'h12345678,  1,  1,  1, 'h0,          0,  0,  0,  'h0, 'h200);
    vt[9]  = mk(1, 'h800,   0, 'h0, 'h0,         1,  1,  1, 'h0,          1,  1,  0,  'h0, 'h200);
    vt[10] = mk(0, 'h000,   0, 'h0, 'h0,         1,  1,  1, 'h0,          0,  1,  0,  'h0, 'h200);
    vt[11] = mk(0, 'h000,   0, 'h0, 'h0,         1,  1,  0, 'h0,          0,  0,  0,  'h0, 'h200);
    vt[12] = mk(1, 'h000,   0, 'h0, 'h0,         1,  1,  0, 'h0,          0,  0,  0,  'h0, 'h000);
    vt[13] = mk(0, 'h000,   0, 'h0, 'h0,         1,  1,  1, 'hA5A5A5A5,   0,  0,  0,  'h0, 'h000);
    vt[14] = mk(0, 'h000,   0, 'h0, 'h0,         1,  1,  0, 'h0,          0,  0,  0,  'h0, 'h000);

    rst = 1'b1; clr = 1'b1; poke_en = 1'b0; poke_idx = '0; poke_val = '0;
    bus_if.req_valid_i = 1'b0; bus_if.req_addr_i = '0; bus_if.req_we_i = 1'b0;
    bus_if.req_be_i = '0; bus_if.req_wdata_i = '0; bus_if.rsp_ready_i = 1'b0;
    @(posedge clk); #1 clr = 1'b0; poke_en = 1'b1; poke_idx = 9'd0; poke_val = 32'hA5A5A5A5;
    @(posedge clk); #1 poke_idx = 9'd9; poke_val = 32'h99990009;
    @(posedge clk); #1 poke_en = 1'b0;
    @(posedge clk); #1 rst = 1'b0; bus_if.rsp_ready_i = 1'b1;
    @(negedge clk);
    chk("reset rsp_valid", bus_if.rsp_valid_o, 0);
    chk("reset req_ready", bus_if.req_ready_o, 1);
    chk("reset rsp_rdata", bus_if.rsp_rdata_o, 0);
    chk("reset rsp_we",    bus_if.rsp_we_o, 0);
    chk("reset rsp_err",   bus_if.rsp_err_o, 0);
    chk("reset ram_addr",  bus_if.ram_addr_o, 0);

    // Directed table: back-to-back writes/reads, partial write, be=0, out of range.
    for (int i = 0; i < NV; i++) begin
      drive(vt[i].v, vt[i].a, vt[i].we, vt[i].be, vt[i].wd, vt[i].rr);
      chk($sformatf("v%0d req_ready", i), bus_if.req_ready_o, vt[i].e_rdy);
      chk($sformatf("v%0d rsp_valid", i), bus_if.rsp_valid_o, vt[i].e_rv);
      chk($sformatf("v%0d ram_we", i),    bus_if.ram_we_o,    vt[i].e_mwe);
      chk($sformatf("v%0d ram_sel", i),   bus_if.ram_sel_o,   vt[i].e_sel);
      chk($sformatf("v%0d ram_addr", i),  bus_if.ram_addr_o,  vt[i].e_addr);
      if (vt[i].e_rv) begin
        chk($sformatf("v%0d rsp_rdata", i), bus_if.rsp_rdata_o, vt[i].e_rd);
        chk($sformatf("v%0d rsp_we", i),    bus_if.rsp_we_o,    vt[i].e_rwe);
        chk($sformatf("v%0d rsp_err", i),   bus_if.rsp_err_o,   vt[i].e_err);
      end
    end

    // Stalled read: response must hold while the RAM word is rewritten behind it.
    drive(1, 'h20, 1, 'hF, 32'hCAFEF00D, 1);
    drive(1, 'h20, 0, 'h0, 0, 1);
    chk("hold wr echo", bus_if.rsp_we_o, 1);
    drive(1, 'h24, 0, 'h0, 0, 0);
    chk("hold c1 rdata", bus_if.rsp_rdata_o, 32'hCAFEF00D);
    chk("hold c1 req_ready", bus_if.req_ready_o, 0);
    @(posedge clk); #1 poke_en = 1'b1; poke_idx = 9'd8; poke_val = 32'h0BADBEEF;
    @(negedge clk);
    chk("hold c2 rdata", bus_if.rsp_rdata_o, 32'hCAFEF00D);
    chk("hold c2 req_ready", bus_if.req_ready_o, 0);
    @(posedge clk); #1 poke_en = 1'b0;
    @(negedge clk);
    chk("hold c3 rdata", bus_if.rsp_rdata_o, 32'hCAFEF00D);
    chk("hold c3 valid", bus_if.rsp_valid_o, 1);
    chk("hold c3 ram_we", bus_if.ram_we_o, 0);
    drive(1, 'h24, 0, 'h0, 0, 1);
    chk("hold release rdata", bus_if.rsp_rdata_o, 32'hCAFEF00D);
    chk("hold release req_ready", bus_if.req_ready_o, 1);
    drive(0, 0, 0, 0, 0, 1);
    chk("after hold rdata", bus_if.rsp_rdata_o, 32'h99990009);
    chk("after hold valid", bus_if.rsp_valid_o, 1);
    drive(0, 0, 0, 0, 0, 1);
    chk("after hold idle", bus_if.rsp_valid_o, 0);

    // Reset while a response is held; a write offered during reset must not land.
    drive(1, 'h0, 0, 'h0, 0, 1);
    drive(0, 0, 0, 0, 0, 0);
    drive(0, 0, 0, 0, 0, 0);
    chk("pre-rst hold valid", bus_if.rsp_valid_o, 1);
    chk("pre-rst hold rdata", bus_if.rsp_rdata_o, 32'hA5A5A5A5);
    @(posedge clk); #1 rst = 1'b1;
    bus_if.req_valid_i = 1'b1; bus_if.req_addr_i = 'h28; bus_if.req_we_i = 1'b1;
    bus_if.req_be_i = 'hF; bus_if.req_wdata_i = 32'h77777777; bus_if.rsp_ready_i = 1'b1;
    @(negedge clk);
    chk("rst ram_we", bus_if.ram_we_o, 0);
    @(posedge clk); #1 rst = 1'b0; bus_if.req_valid_i = 1'b0;
    @(negedge clk);
    chk("post-rst valid", bus_if.rsp_valid_o, 0);
    chk("post-rst req_ready", bus_if.req_ready_o, 1);
    for (int i = 0; i < 3; i++) begin
      drive(0, 0, 0, 0, 0, 1);
      chk($sformatf("post-rst idle%0d", i), bus_if.rsp_valid_o, 0);
    end
    drive(1, 'h28, 0, 'h0, 0, 1);
    drive(0, 0, 0, 0, 0, 1);
    chk("post-rst word10", {bus_if.rsp_valid_o, bus_if.rsp_rdata_o}, {1'b1, 32'h0});

    // Random traffic against a reference memory, random response back-pressure.
    begin
      int issued = 0, got = 0, cyc = 0;
      logic pend = 1'b0;
      logic [31:0] pa, pwd;
      logic pwe;
      logic [3:0] pbe;
      for (int i = 0; i < 16; i++) ref_mem[i] = mem[i];
      while ((issued < 100 || q.size() > 0) && cyc < 3000) begin
        @(posedge clk); #1;
        if (!pend && issued < 100) begin
          int w;
          w   = $urandom_range(0, 15);
          pa  = ($urandom_range(0, 7) == 0) ? (32'h800 + 32'(w) * 4) : (32'(w) * 4 + $urandom_range(0, 3));
          pwe = 1'($urandom_range(0, 1));
          pbe = 4'($urandom_range(0, 15));
          pwd = $urandom;
          pend = 1'b1;
        end
        bus_if.req_valid_i = pend;
        bus_if.req_addr_i  = pa;
        bus_if.req_we_i    = pwe;
        bus_if.req_be_i    = pbe;
        bus_if.req_wdata_i = pwd;
        bus_if.rsp_ready_i = ($urandom_range(0, 3) != 0);
        @(negedge clk);
        if (bus_if.rsp_valid_o && bus_if.rsp_ready_i) begin
          got++;
          if (q.size() == 0) begin
            chk("rand unexpected rsp", 1, 0);
          end else begin
            exp_t e;
            e = q.pop_front();
            chk($sformatf("rand rsp%0d", got),
                {bus_if.rsp_rdata_o, bus_if.rsp_we_o, bus_if.rsp_err_o}, {e.rd, e.we, e.err});
          end
        end
        if (bus_if.req_valid_i && bus_if.req_ready_o) begin
          exp_t e;
          logic oor;
          int   w;
          oor = pa >= 32'h800;
          w   = int'(pa[5:2]);
          e.we  = pwe;
          e.err = oor;
          e.rd  = (!oor && !pwe) ? ref_mem[w] : 32'h0;
          q.push_back(e);
          if (!oor && pwe)
            for (int b = 0; b < 4; b++)
              if (pbe[b]) ref_mem[w][8*b +: 8] = pwd[8*b +: 8];
          pend = 1'b0;
          issued++;
        end
        cyc++;
      end
      chk("rand drained", {32'(issued), 32'(q.size())}, {32'd100, 32'd0});
      chk("rand responses", got, 100);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
